// File: rtl/selftrigger_frame_builder_if.sv
// Valid/ready frame-word stream between the frame builder and the readout FIFO/merger.
interface selftrigger_frame_builder_if;
   logic [31:0] dout;
   logic        dout_valid;
   logic        dout_ready;
   logic        dout_last;

   modport master (output dout, output dout_valid, output dout_last, input dout_ready);
   modport slave  (input dout, input dout_valid, input dout_last, output dout_ready);
endinterface

// File: rtl/selftrigger_frame_builder.sv
// Per-channel self-trigger frame builder: ring-buffers samples and emits header/timestamp/window frames.
// Define SELFTRIG_FRAME_TRAILER_EN to append a {dropped_count, 16'hEDED} trailer word.
module selftrigger_frame_builder #(
   parameter int CH_ID    = 0,
   parameter int PRE_LEN  = 64,
   parameter int POST_LEN = 192,
   parameter int BUF_AW   = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic signed [15:0]          x,
   input  logic                        trigger,
   input  logic [63:0]                 timestamp,
   selftrigger_frame_builder_if.master frame_bus,
   output logic                        busy,
   output logic [15:0]                 dropped_count
);
   localparam int BUF_DEPTH    = 1 << BUF_AW;
   localparam int SAMPLE_WORDS = (PRE_LEN + POST_LEN) / 2;
`ifdef SELFTRIG_FRAME_TRAILER_EN
   localparam int NUM_WORDS = 3 + SAMPLE_WORDS + 1;
`else
   localparam int NUM_WORDS = 3 + SAMPLE_WORDS;
`endif
   localparam int WI_W = $clog2(NUM_WORDS + 1);
   localparam int PC_W = $clog2(POST_LEN + 1);
   localparam int AC_W = $clog2(PRE_LEN + 1);

   localparam logic [WI_W-1:0]   WORDS_DONE        = WI_W'(NUM_WORDS);
   localparam logic [WI_W-1:0]   LAST_WORD         = WI_W'(NUM_WORDS - 1);
   localparam logic [WI_W-1:0]   FIRST_SAMPLE_WORD = WI_W'(3);
   localparam logic [WI_W-1:0]   LAST_SAMPLE_WORD  = WI_W'(3 + SAMPLE_WORDS - 1);
   localparam logic [PC_W-1:0]   POST_LAST         = PC_W'(POST_LEN - 1);
   localparam logic [AC_W-1:0]   ARM_LAST          = AC_W'(PRE_LEN - 1);
   localparam logic [BUF_AW-1:0] PRE_OFFSET        = BUF_AW'(PRE_LEN);
   localparam logic [31:0]       HEADER            = {8'hBE, 8'(CH_ID), 16'(PRE_LEN + POST_LEN)};

   typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_CAPTURE, ST_READOUT} state_t;

   state_t            state_reg, state_next;
   logic [BUF_AW-1:0] wptr_reg;
   logic [AC_W-1:0]   arm_cnt_reg, arm_cnt_next;
   logic [PC_W-1:0]   post_cnt_reg, post_cnt_next;
   logic [BUF_AW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [63:0]       ts_reg, ts_next;
   logic [WI_W-1:0]   w_idx_reg, w_idx_next;
   logic              trigger_d_reg;
   logic [15:0]       dropped_reg;

   logic [31:0]       dout_reg, skid_reg;
   logic              valid_reg, last_reg, skid_valid_reg, skid_last_reg;

   logic        trig_edge, wr_en, pop, issue, issue_sample, issue_last;
   logic [31:0] issue_word;

   assign trig_edge = enable & trigger & ~trigger_d_reg;
   assign wr_en     = enable & (state_reg != ST_READOUT);
   assign pop       = valid_reg & frame_bus.dout_ready;

   // Issue only while the skid slot is free, so dout_ready never reaches the issue path.
   assign issue        = (state_reg == ST_READOUT) && !skid_valid_reg && (w_idx_reg != WORDS_DONE);
   assign issue_sample = issue && (w_idx_reg >= FIRST_SAMPLE_WORD) && (w_idx_reg <= LAST_SAMPLE_WORD);
   assign issue_last   = (w_idx_reg == LAST_WORD);

   // Two identical sample copies give the even and odd sample of a pair in one read.
   // Read address is the next pointer, so rdata always matches rd_ptr_reg.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_bank
         logic [15:0] mem [BUF_DEPTH];
         logic [15:0] rdata;
         always_ff @(posedge clk) begin
            if (wr_en)
               mem[wptr_reg] <= x;
            rdata <= mem[rd_ptr_next + BUF_AW'(gi)];
         end
      end
   endgenerate

   always_comb begin
      issue_word = {g_bank[1].rdata, g_bank[0].rdata};
      if (w_idx_reg == WI_W'(0))
         issue_word = HEADER;
      else if (w_idx_reg == WI_W'(1))
         issue_word = ts_reg[63:32];
      else if (w_idx_reg == WI_W'(2))
         issue_word = ts_reg[31:0];
`ifdef SELFTRIG_FRAME_TRAILER_EN
      else if (w_idx_reg == LAST_WORD)
         issue_word = {dropped_reg, 16'hEDED};
`endif
   end

   always_comb begin
      state_next    = state_reg;
      arm_cnt_next  = arm_cnt_reg;
      post_cnt_next = post_cnt_reg;
      rd_ptr_next   = rd_ptr_reg;
      ts_next       = ts_reg;
      w_idx_next    = w_idx_reg;
      case (state_reg)
         ST_ARM: begin
            if (enable) begin
               if (arm_cnt_reg == ARM_LAST) begin
                  state_next   = ST_IDLE;
                  arm_cnt_next = '0;
               end else begin
                  arm_cnt_next = arm_cnt_reg + AC_W'(1);
               end
            end
         end
         ST_IDLE: begin
            // The sample written in the edge cycle is post-sample 0.
            if (trig_edge) begin
               state_next    = ST_CAPTURE;
               post_cnt_next = PC_W'(1);
               rd_ptr_next   = wptr_reg - PRE_OFFSET;
               ts_next       = timestamp;
            end
         end
         ST_CAPTURE: begin
            if (enable) begin
               if (post_cnt_reg == POST_LAST) begin
                  state_next = ST_READOUT;
                  w_idx_next = '0;
               end else begin
                  post_cnt_next = post_cnt_reg + PC_W'(1);
               end
            end
         end
         ST_READOUT: begin
            if (issue)
               w_idx_next = w_idx_reg + WI_W'(1);
            if (issue_sample)
               rd_ptr_next = rd_ptr_reg + BUF_AW'(2);
            if (pop && last_reg) begin
               state_next   = ST_ARM;
               arm_cnt_next = '0;
            end
         end
         default: state_next = ST_ARM;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_ARM;
         wptr_reg      <= '0;
         arm_cnt_reg   <= '0;
         post_cnt_reg  <= '0;
         rd_ptr_reg    <= '0;
         ts_reg        <= '0;
         w_idx_reg     <= '0;
         trigger_d_reg <= 1'b0;
         dropped_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         arm_cnt_reg   <= arm_cnt_next;
         post_cnt_reg  <= post_cnt_next;
         rd_ptr_reg    <= rd_ptr_next;
         ts_reg        <= ts_next;
         w_idx_reg     <= w_idx_next;
         trigger_d_reg <= trigger;
         if (wr_en)
            wptr_reg <= wptr_reg + BUF_AW'(1);
         if (trig_edge && (state_reg != ST_IDLE) && (dropped_reg != 16'hFFFF))
            dropped_reg <= dropped_reg + 16'd1;
      end
   end

   // Two-entry output stage: head register drives the bus, skid catches the in-flight word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout_reg       <= '0;
         valid_reg      <= 1'b0;
         last_reg       <= 1'b0;
         skid_reg       <= '0;
         skid_valid_reg <= 1'b0;
         skid_last_reg  <= 1'b0;
      end else if (issue) begin
         if (!valid_reg || pop) begin
            dout_reg  <= issue_word;
            last_reg  <= issue_last;
            valid_reg <= 1'b1;
         end else begin
            skid_reg       <= issue_word;
            skid_last_reg  <= issue_last;
            skid_valid_reg <= 1'b1;
         end
      end else if (pop) begin
         if (skid_valid_reg) begin
            dout_reg       <= skid_reg;
            last_reg       <= skid_last_reg;
            skid_valid_reg <= 1'b0;
         end else begin
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
         end
      end
   end

   assign frame_bus.dout       = dout_reg;
   assign frame_bus.dout_valid = valid_reg;
   assign frame_bus.dout_last  = last_reg;
   assign busy                 = (state_reg == ST_CAPTURE) || (state_reg == ST_READOUT);
   assign dropped_count        = dropped_reg;

endmodule

// File: tb/tb_selftrigger_frame_builder.sv
// Scoreboard bench for selftrigger_frame_builder (PRE_LEN=8, POST_LEN=24, BUF_AW=5, CH_ID=3, ramp input).
module tb_selftrigger_frame_builder;
   localparam logic [63:0] TS_BASE = 64'h0000_0001_FFFF_FFE0;
`ifdef SELFTRIG_FRAME_TRAILER_EN
   localparam int NUM_WORDS = 20;
`else
   localparam int NUM_WORDS = 19;
`endif
   localparam int RUN_CYCLES = 180;

   logic               clk;
   logic               reset;
   logic               enable;
   logic signed [15:0] x;
   logic               trigger;
   logic [63:0]        timestamp;
   logic               busy;
   logic [15:0]        dropped_count;

   selftrigger_frame_builder_if bus ();

   selftrigger_frame_builder #(
      .CH_ID(3), .PRE_LEN(8), .POST_LEN(24), .BUF_AW(5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .x(x),
      .trigger(trigger),
      .timestamp(timestamp),
      .frame_bus(bus),
      .busy(busy),
      .dropped_count(dropped_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n = 0;
   int          exp_drops = 0;
   logic [32:0] sb [$];

   int          xfer_cnt = 0;
   int          frames_seen = 0;
   int          first_valid_cyc = -1;
   int          last_xfer_cyc = -1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, n);
      end
   endtask

   task automatic push_frame(input int t);
      logic [63:0] ts;
      logic [15:0] lo_s, hi_s;
      logic        lst;
      ts = TS_BASE + 64'(t);
      sb.push_back({1'b0, 32'hBE03_0020});
      sb.push_back({1'b0, ts[63:32]});
      sb.push_back({1'b0, ts[31:0]});
      for (int k = 0; k < 16; k++) begin
         lo_s = 16'(t - 8 + 2 * k);
         hi_s = 16'(t - 7 + 2 * k);
`ifdef SELFTRIG_FRAME_TRAILER_EN
         lst = 1'b0;
`else
         lst = (k == 15);
`endif
         sb.push_back({lst, hi_s, lo_s});
      end
`ifdef SELFTRIG_FRAME_TRAILER_EN
      sb.push_back({1'b1, 16'(exp_drops), 16'hEDED});
`endif
   endtask

   task automatic start_run();
      @(posedge clk); #1;
      reset = 1'b0;
      trigger = 1'b0;
      enable = 1'b1;
      bus.dout_ready = 1'b1;
      x = '0;
      timestamp = TS_BASE;
      sb.delete();
      #1;
      check("rst_dout", 64'(bus.dout), 64'd0);
      check("rst_valid", 64'(bus.dout_valid), 64'd0);
      check("rst_last", 64'(bus.dout_last), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_dropped", 64'(dropped_count), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      n = 0;
      x = '0;
      timestamp = TS_BASE;
   endtask

   task automatic step(input int p0, input int p1, input int p2, input int acc, input bit bp);
      @(posedge clk); #1;
      n++;
      x = 16'(n);
      timestamp = TS_BASE + 64'(n);
      trigger = (n == p0) || (n == p1) || (n == p2);
      bus.dout_ready = bp ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
      if (n == acc)
         push_frame(acc);
   endtask

   task automatic run_frame(input int p0, input int p1, input int p2, input int acc,
                            input int drops, input bit bp);
      exp_drops = drops;
      start_run();
      for (int i = 0; i < RUN_CYCLES; i++) begin
         step(p0, p1, p2, acc, bp);
         if (n == acc)
            check("busy_before_accept", 64'(busy), 64'd0);
         if (n == acc + 1)
            check("busy_rise", 64'(busy), 64'd1);
      end
      check("sb_drained", 64'(sb.size()), 64'd0);
      check("frames_seen", 64'(frames_seen), 64'd1);
      check("dropped_count", 64'(dropped_count), 64'(drops));
      check("w0_latency", 64'(first_valid_cyc), 64'(acc + 25));
      if (!bp)
         check("stream_len", 64'(last_xfer_cyc - first_valid_cyc + 1), 64'(NUM_WORDS));
      check("busy_end", 64'(busy), 64'd0);
   endtask

   // Output monitor: pops the scoreboard on every transfer and checks stall stability.
   initial begin
      logic        prev_stall;
      logic [31:0] prev_dout;
      logic        prev_last;
      logic        busy_fall_pending;
      logic [32:0] exp_w;
      prev_stall = 1'b0;
      prev_dout = '0;
      prev_last = 1'b0;
      busy_fall_pending = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_stall = 1'b0;
            busy_fall_pending = 1'b0;
            xfer_cnt = 0;
            frames_seen = 0;
            first_valid_cyc = -1;
            last_xfer_cyc = -1;
         end else begin
            if (busy_fall_pending) begin
               check("busy_fall", 64'(busy), 64'd0);
               busy_fall_pending = 1'b0;
            end
            if (prev_stall)
               check("stall_hold", {30'b0, bus.dout_valid, bus.dout_last, bus.dout},
                     {30'b0, 1'b1, prev_last, prev_dout});
            if (bus.dout_valid && first_valid_cyc < 0)
               first_valid_cyc = n;
            if (bus.dout_valid && bus.dout_ready) begin
               $display("xfer cyc=%0d dout=0x%08h last=%0b", n, bus.dout, bus.dout_last);
               check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
               if (sb.size() != 0) begin
                  exp_w = sb.pop_front();
                  check("frame_word", {31'b0, bus.dout_last, bus.dout}, {31'b0, exp_w});
               end
               xfer_cnt++;
               if (bus.dout_last) begin
                  frames_seen++;
                  last_xfer_cyc = n;
                  busy_fall_pending = 1'b1;
               end
            end
            prev_stall = bus.dout_valid && !bus.dout_ready;
            prev_dout = bus.dout;
            prev_last = bus.dout_last;
         end
      end
   end

   initial begin
      int guard;
      reset = 1'b0;
      enable = 1'b1;
      trigger = 1'b0;
      x = '0;
      timestamp = TS_BASE;
      bus.dout_ready = 1'b1;

      run_frame(40, -1, -1, 40, 0, 1'b0);   // basic frame
      run_frame(5, 20, -1, 20, 1, 1'b0);    // early trigger dropped in ARM
      run_frame(40, 50, 70, 40, 2, 1'b0);   // retrigger in capture and readout
      run_frame(40, -1, -1, 40, 0, 1'b1);   // back-pressure 1,0,0,1
      run_frame(45, -1, -1, 45, 0, 1'b0);   // window wraps the ring

      // Reset in the middle of readout, right after W1 transfers.
      exp_drops = 1;
      start_run();
      guard = 0;
      while (xfer_cnt < 2 && guard < 120) begin
         step(5, 40, -1, 40, 1'b0);
         guard++;
      end
      check("w1_reached", 64'(xfer_cnt >= 2), 64'd1);
      check("dropped_before_reset", 64'(dropped_count), 64'd1);
      reset = 1'b0;
      #1;
      check("midrst_valid", 64'(bus.dout_valid), 64'd0);
      check("midrst_last", 64'(bus.dout_last), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_dropped", 64'(dropped_count), 64'd0);
      sb.delete();
      // Edge on the 8th write after release is still in ARM; two cycles later it is accepted.
      run_frame(7, 9, -1, 9, 1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/selftrigger_frame_builder.md
# selftrigger_frame_builder

Per-channel consumer of the self-trigger path: records the filtered sample stream `y` and the matching `trigger_output` bit from the filter/trigger stage, and turns each accepted trigger into a framed record on a 32-bit valid/ready stream. The frame carries a header, a timestamp, a pre/post-trigger sample window and an optional trailer. One instance sits per channel, between the filter/trigger stage and the readout FIFO/merger.

## Interface

Parameters:
- `CH_ID`, 0: 8-bit channel number written into the header.
- `PRE_LEN`, 64: samples kept before the trigger. Must be even and ≥ 2.
- `POST_LEN`, 192: samples from the trigger cycle onward. Must be even and ≥ 2.
- `BUF_AW`, 8: ring-buffer address width. Requires PRE_LEN+POST_LEN ≤ 2^BUF_AW.

Ports:
- `clk` in 1: sample clock, one sample per cycle.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: when 0, no buffer writes and no trigger acceptance. State is held.
- `x` in 16, signed: filtered sample for this channel.
- `trigger` in 1: self-trigger bit for this channel.
- `timestamp` in 64: free-running timestamp, aligned with `x`.
- `dout` out 32: frame word.
- `dout_valid` out 1: `dout` is valid.
- `dout_ready` in 1: downstream accepts the word.
- `dout_last` out 1: marks the final word of the frame.
- `busy` out 1: high in CAPTURE or READOUT.
- `dropped_count` out 16: number of triggers lost; saturates at 0xFFFF.

## Operation

- The ring buffer holds 2^BUF_AW × 16-bit samples. While `enable`=1 in ARM, IDLE or CAPTURE, `x` is written at `wptr` and `wptr` increments (mod 2^BUF_AW). Writes stop in READOUT.
- A trigger edge is `trigger & ~trigger_d` while `enable`=1. `trigger_d` is a registered copy of `trigger`.
- States:
  - ARM: counts written samples. Moves to IDLE once PRE_LEN samples have been written since entry. Reset enters ARM with count 0.
  - IDLE: on a trigger edge, latch `timestamp` and set `start = wptr - PRE_LEN` (mod). The sample written in the edge cycle is post-sample 0. Go to CAPTURE with post count 1.
  - CAPTURE: each enabled cycle writes one sample and increments the post count. After POST_LEN samples in total, go to READOUT.
  - READOUT: emits the frame, then goes to ARM with count 0.
- Frame words, in order:
  - W0 = {8'hBE, CH_ID, 16'(PRE_LEN+POST_LEN)}
  - W1 = timestamp[63:32]
  - W2 = timestamp[31:0]
  - (PRE_LEN+POST_LEN)/2 sample words, each {sample[2k+1], sample[2k]}, read from `start` upward (mod).
  - Trailer: see Configuration.
- Dropped triggers: a trigger edge in ARM, CAPTURE or READOUT increments `dropped_count`, saturating at 0xFFFF. A trigger edge in IDLE is always accepted.
- Handshake:
  - A word transfers when `dout_valid` & `dout_ready`.
  - While `dout_valid`=1 and `dout_ready`=0, `dout`, `dout_valid` and `dout_last` hold stable.
  - `dout_valid` never drops without a transfer.
- `enable`=0 in CAPTURE freezes the post count and writes. Readout is unaffected by `enable`.
- Reset mid-operation: the frame is abandoned, with no partial `dout_last`. All outputs and counters return to their reset values.

## Timing

- Reset values: `dout`=0, `dout_valid`=0, `dout_last`=0, `busy`=0, `dropped_count`=0, state ARM.
- Buffer read latency is 1 cycle. A 2-entry output skid register allows one word per cycle under continuous `dout_ready`=1.
- W0 asserts `dout_valid` exactly 2 cycles after the cycle in which the last post-trigger sample is written.
- With `dout_ready` held at 1, the whole frame streams in consecutive cycles. Frame length is 3 + (PRE_LEN+POST_LEN)/2 (+1 with the trailer) words.
- `busy` rises the cycle after the accepted edge. It falls the cycle after the final word transfers.
- The earliest next acceptance is PRE_LEN enabled cycles after READOUT ends.

## Configuration

- `SELFTRIG_FRAME_TRAILER_EN` defined:
  - A trailer word {dropped_count, 16'hEDED} follows the last sample word and carries `dout_last`.
  - `dropped_count` in the trailer is the value sampled when the trailer is loaded.
- Undefined:
  - No trailer; `dout_last` is on the last sample word.
  - `dropped_count` is still maintained on its port.

## Test plan

Bench parameters: PRE_LEN=8, POST_LEN=24, BUF_AW=5, CH_ID=3, `x` = ramp value n at cycle n, `dout_ready`=1.

- Basic frame: reset released, trigger pulse at cycle 40 → W0=0xBE030020, W1/W2 = timestamp at cycle 40, first sample word = {33,32}, last sample word = {63,62}, 16 sample words. `dout_last` on the trailer (macro on) or on {63,62} (macro off).
- Early trigger: trigger at cycle 5 (still in ARM) → no frame, `dropped_count`=1. A trigger at cycle 20 produces a frame with first sample word {13,12}.
- Retrigger during capture/readout: pulses at 40, 50 and 70 → one frame only, `dropped_count`=2, trailer low half 0xEDED and high half 0x0002.
- Back-pressure: `dout_ready` toggles 1,0,0,1 repeatedly → word sequence is identical to the basic frame, and `dout` is stable on every stalled cycle.
- Wrap-around: trigger at cycle 45 (start = wptr-8 crosses address 31→0) → samples contiguous 37..68 in order.
- Reset mid-readout: assert `reset` low after W1 transfers → `dout_valid`=0, `busy`=0, `dropped_count`=0 immediately. The next frame needs ≥ 8 samples written after release.
